// File: rtl/framebuffer_scanout_if.sv
// framebuffer_scanout_if: groups the framebuffer read port and the outgoing pixel stream.
// master = scanout engine, slave = framebuffer plus display sink.
interface framebuffer_scanout_if #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned COLOR_W = 24
) ();
    // Framebuffer read port
    logic               read_en;
    logic [COORD_W-1:0] read_x;
    logic [COORD_W-1:0] read_y;
    logic [COLOR_W-1:0] read_color;

    // Pixel stream towards the sink
    logic               out_valid;
    logic               out_ready;
    logic [COLOR_W-1:0] out_color;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic               out_sof;
    logic               out_eol;
    logic               out_eof;

    modport master (
        output read_en, read_x, read_y,
        input  read_color,
        output out_valid, out_color, out_x, out_y, out_sof, out_eol, out_eof,
        input  out_ready
    );

    modport slave (
        input  read_en, read_x, read_y,
        output read_color,
        input  out_valid, out_color, out_x, out_y, out_sof, out_eol, out_eof,
        output out_ready
    );
endinterface

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster-order read master for the framebuffer. Issues reads x-fastest,
// returns colours as a valid/ready pixel stream with coordinates and sof/eol/eof markers.
// Optional feature macro: SCANOUT_CONTINUOUS_EN (free-running frames after one start).
//
// Return path is a 2-entry queue with a fall-through bypass: when the queue is empty the
// read data arriving this cycle is presented directly, giving out_valid 2 clk after start.
// A read is issued only if the queue can still hold it once it returns, counting the read
// still in flight, so the queue never overflows.
module framebuffer_scanout #(
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned V_ACTIVE = 256,
    parameter int unsigned COORD_W  = 8,
    parameter int unsigned COLOR_W  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    framebuffer_scanout_if.master bus
);
    localparam logic [COORD_W-1:0] XLast = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] YLast = COORD_W'(V_ACTIVE - 1);

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pixel_t;

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

    state_e             state_q;
    logic [COORD_W-1:0] nx_q, ny_q;    // coordinate of the next read to issue
    logic [COORD_W-1:0] lx_q, ly_q;    // coordinate of the most recently issued read
    logic               inflight_q;    // read issued last cycle, data arrives now
    logic [1:0]         q_count_q;
    pixel_t             e0_q, e1_q;    // e0 is the queue head

    logic   issue;
    logic   last_issue;
    logic   push;
    logic   pop;
    logic   head_eof;
    pixel_t incoming;
    pixel_t head;

    // Issue decision, head selection and stream outputs.
    always_comb begin
        incoming       = '{color: bus.read_color, x: lx_q, y: ly_q};
        push           = inflight_q;
        bus.out_valid  = (q_count_q != 2'd0) || inflight_q;
        if (q_count_q != 2'd0) begin
            head = e0_q;
        end else if (inflight_q) begin
            head = incoming;
        end else begin
            head = '0;
        end
        pop        = bus.out_valid && bus.out_ready;
        issue      = (state_q == StScan) &&
                     ((3'(q_count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
        last_issue = issue && (nx_q == XLast) && (ny_q == YLast);
        head_eof   = (head.x == XLast) && (head.y == YLast);

        bus.read_en   = issue;
        bus.read_x    = issue ? nx_q : lx_q;
        bus.read_y    = issue ? ny_q : ly_q;
        bus.out_color = head.color;
        bus.out_x     = head.x;
        bus.out_y     = head.y;
        bus.out_sof   = bus.out_valid && (head.x == '0) && (head.y == '0);
        bus.out_eol   = bus.out_valid && (head.x == XLast);
        bus.out_eof   = bus.out_valid && head_eof;
        // Only the last pixel of a frame carries eof, so its acceptance ends the frame.
        frame_done    = pop && head_eof;
        busy          = (state_q != StIdle);
    end

    // Scan FSM with read coordinate counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            nx_q       <= '0;
            ny_q       <= '0;
            lx_q       <= '0;
            ly_q       <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                lx_q <= nx_q;
                ly_q <= ny_q;
                if (nx_q == XLast) begin
                    nx_q <= '0;
                    ny_q <= (ny_q == YLast) ? '0 : ny_q + 1'b1;
                end else begin
                    nx_q <= nx_q + 1'b1;
                end
            end
            case (state_q)
                StIdle: begin
                    if (start) state_q <= StScan;
                end
                StScan: begin
`ifdef SCANOUT_CONTINUOUS_EN
                    // Coordinates already wrap to (0,0); keep scanning the next frame.
                    if (last_issue) state_q <= StScan;
`else
                    if (last_issue) state_q <= StDrain;
`endif
                end
                StDrain: begin
                    if (frame_done) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Return-path queue: capture the returning read, drop the head on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_count_q <= 2'd0;
            e0_q      <= '0;
            e1_q      <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (q_count_q == 2'd0) e0_q <= incoming;
                    else                   e1_q <= incoming;
                    q_count_q <= q_count_q + 2'd1;
                end
                2'b11: begin
                    // Empty queue: the returning pixel was accepted through the bypass.
                    if (q_count_q != 2'd0) e0_q <= incoming;
                end
                2'b01: begin
                    e0_q      <= e1_q;
                    q_count_q <= q_count_q - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: directed bench for framebuffer_scanout.
// Several instances share one clock: 4x4, 1x1, 256x32 and 2x2 (continuous-mode build).
module tb_framebuffer_scanout;
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start4 = 1'b0;
    logic start1 = 1'b0;
    logic startb = 1'b0;
    logic start2 = 1'b0;
    logic busy4, busy1, busyb, busy2;
    logic fd4, fd1, fdb, fd2;

    int total = 0;
    int bad   = 0;
    int issued, accepted, maxo, fd_cnt, first_v, idx, found, rd_cnt;
    logic done, pend_start;

    always #5 clk = ~clk;

    function automatic logic [23:0] col(input logic [7:0] x, input logic [7:0] y);
        return {y, x, 8'hA5};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    framebuffer_scanout_if #(.COORD_W(8), .COLOR_W(24)) fbi4 ();
    framebuffer_scanout_if #(.COORD_W(8), .COLOR_W(24)) fbi1 ();
    framebuffer_scanout_if #(.COORD_W(8), .COLOR_W(24)) fbib ();
    framebuffer_scanout_if #(.COORD_W(8), .COLOR_W(24)) fbi2 ();

    framebuffer_scanout #(.H_ACTIVE(4), .V_ACTIVE(4), .COORD_W(8), .COLOR_W(24)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .frame_done(fd4), .bus(fbi4)
    );
    framebuffer_scanout #(.H_ACTIVE(1), .V_ACTIVE(1), .COORD_W(8), .COLOR_W(24)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .frame_done(fd1), .bus(fbi1)
    );
    framebuffer_scanout #(.H_ACTIVE(256), .V_ACTIVE(32), .COORD_W(8), .COLOR_W(24)) dutb (
        .clk(clk), .rst_n(rst_n), .start(startb), .busy(busyb), .frame_done(fdb), .bus(fbib)
    );
    framebuffer_scanout #(.H_ACTIVE(2), .V_ACTIVE(2), .COORD_W(8), .COLOR_W(24)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .frame_done(fd2), .bus(fbi2)
    );

    // Framebuffer models: colour valid exactly one clock after read_en.
    always @(posedge clk) if (fbi4.read_en) fbi4.read_color <= col(fbi4.read_x, fbi4.read_y);
    always @(posedge clk) if (fbi1.read_en) fbi1.read_color <= col(fbi1.read_x, fbi1.read_y);
    always @(posedge clk) if (fbib.read_en) fbib.read_color <= col(fbib.read_x, fbib.read_y);
    always @(posedge clk) if (fbi2.read_en) fbi2.read_color <= col(fbi2.read_x, fbi2.read_y);

    typedef struct packed {
        logic        busy;
        logic        ren;
        logic [7:0]  rx;
        logic [7:0]  ry;
        logic        ov;
        logic [7:0]  ox;
        logic [7:0]  oy;
        logic        sof;
        logic        eol;
        logic        eof;
        logic        fd;
        logic [23:0] color;
    } vec_t;

    vec_t tab [19];
    vec_t obs;

    initial begin
        // Full-rate 4x4 frame, start in cycle 0.
        for (int k = 0; k < 19; k++) begin
            int p;
            int r;
            p = k - 2;
            r = k - 1;
            tab[k]      = '0;
            tab[k].busy = (k >= 1) && (k <= 17);
            tab[k].ren  = (k >= 1) && (k <= 16);
            tab[k].rx   = (k == 0) ? 8'd0 : (k <= 16) ? 8'(r % 4) : 8'd3;
            tab[k].ry   = (k == 0) ? 8'd0 : (k <= 16) ? 8'(r / 4) : 8'd3;
            if (k >= 2 && k <= 17) begin
                tab[k].ov    = 1'b1;
                tab[k].ox    = 8'(p % 4);
                tab[k].oy    = 8'(p / 4);
                tab[k].sof   = (p == 0);
                tab[k].eol   = ((p % 4) == 3);
                tab[k].eof   = (p == 15);
                tab[k].color = col(8'(p % 4), 8'(p / 4));
            end
            tab[k].fd = (k == 17);
        end

        fbi4.out_ready = 1'b1;
        fbi1.out_ready = 1'b1;
        fbib.out_ready = 1'b1;
        fbi2.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset4", {busy4, fd4, fbi4.read_en, fbi4.out_valid, fbi4.read_x, fbi4.read_y}, '0);
        chk("resetb", {busyb, fdb, fbib.read_en, fbib.out_valid}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef SCANOUT_CONTINUOUS_EN
        // One start, frames repeat forever.
        accepted = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            start2 = (c == 0);
            #1;
            if (c >= 1) chk($sformatf("cont_busy[%0d]", c), busy2, 1'b1);
            if (fbi2.out_valid && fbi2.out_ready) begin
                chk($sformatf("cont_pix[%0d]", accepted), {fbi2.out_x, fbi2.out_y, fd2},
                    {8'(accepted % 2), 8'((accepted / 2) % 2), 1'((accepted % 4) == 3)});
                accepted++;
            end else begin
                chk($sformatf("cont_nofd[%0d]", c), fd2, 1'b0);
            end
        end
        chk("cont_count", accepted, 24);
`else
        // Table-driven full-rate frame.
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            start4 = (k == 0);
            #1;
            obs      = '0;
            obs.busy = busy4;
            obs.ren  = fbi4.read_en;
            obs.rx   = fbi4.read_x;
            obs.ry   = fbi4.read_y;
            obs.ov   = fbi4.out_valid;
            obs.fd   = fd4;
            if (tab[k].ov) begin
                obs.ox    = fbi4.out_x;
                obs.oy    = fbi4.out_y;
                obs.sof   = fbi4.out_sof;
                obs.eol   = fbi4.out_eol;
                obs.eof   = fbi4.out_eof;
                obs.color = fbi4.out_color;
            end
            chk($sformatf("vec4[%0d]", k), 128'(obs), 128'(tab[k]));
        end

        // 1x1 frame: one pixel carries sof, eol and eof together.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start1 = (k == 0);
            #1;
            if (k == 1) chk("one_c1", {busy1, fbi1.read_en, fbi1.out_valid}, 3'b110);
            if (k == 2) chk("one_c2", {fbi1.out_valid, fbi1.out_sof, fbi1.out_eol,
                                       fbi1.out_eof, fd1, busy1}, 6'b111111);
            if (k == 3) chk("one_c3", {busy1, fbi1.out_valid, fbi1.read_en}, 3'b000);
        end

        // Backpressure: sink stalls for 10 clk after the first valid pixel.
        issued = 0; accepted = 0; maxo = 0; fd_cnt = 0; first_v = -1; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            start4 = (c == 0);
            fbi4.out_ready = (first_v >= 0) && (c >= first_v + 10);
            #1;
            if (fbi4.out_valid && first_v < 0) first_v = c;
            if (fbi4.read_en) issued++;
            if (fbi4.out_valid && !fbi4.out_ready)
                chk($sformatf("bp_hold[%0d]", c), {fbi4.out_x, fbi4.out_y, fbi4.out_color},
                    {8'd0, 8'd0, col(8'd0, 8'd0)});
            if (fbi4.out_valid && fbi4.out_ready) begin
                chk($sformatf("bp_pix[%0d]", accepted), {fbi4.out_x, fbi4.out_y},
                    {8'(accepted % 4), 8'(accepted / 4)});
                accepted++;
            end
            if (issued - accepted > maxo) maxo = issued - accepted;
            if (fd4) fd_cnt++;
            if (c > 0 && !busy4) done = 1'b1;
        end
        chk("bp_done", done, 1'b1);
        chk("bp_count", accepted, 16);
        chk("bp_issued", issued, 16);
        chk("bp_maxout", maxo, 2);
        chk("bp_fd", fd_cnt, 1);

        // Asynchronous reset in the middle of a scan.
        found = 0;
        fbib.out_ready = 1'b1;
        for (int c = 0; c < 3000 && found == 0; c++) begin
            @(negedge clk);
            startb = (c == 0);
            #1;
            if (fbib.read_en && fbib.read_x == 8'd37 && fbib.read_y == 8'd5) found = 1;
        end
        chk("rst_reach", found, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", {busyb, fdb, fbib.read_en, fbib.read_x, fbib.read_y, fbib.out_valid,
                         fbib.out_color, fbib.out_x, fbib.out_y, fbib.out_sof, fbib.out_eol,
                         fbib.out_eof}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (fbib.read_en || busyb) rd_cnt++;
        end
        chk("rst_noread", rd_cnt, 0);

        // Random sink, 256x32 frame, start retried while busy at pixel 100.
        idx = 0; fd_cnt = 0; done = 1'b0; pend_start = 1'b0;
        for (int c = 0; c < 40000 && !done; c++) begin
            @(negedge clk);
            startb     = (c == 0) || pend_start;
            pend_start = 1'b0;
            fbib.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (fbib.out_valid && fbib.out_ready) begin
                chk($sformatf("pix[%0d]", idx),
                    {fbib.out_x, fbib.out_y, fbib.out_color, fbib.out_sof, fbib.out_eol,
                     fbib.out_eof},
                    {8'(idx % 256), 8'(idx / 256), col(8'(idx % 256), 8'(idx / 256)),
                     1'(idx == 0), 1'((idx % 256) == 255), 1'(idx == 8191)});
                if (idx == 100) pend_start = 1'b1;
                idx++;
            end
            if (fdb) fd_cnt++;
            if (c > 0 && !busyb) done = 1'b1;
        end
        chk("rand_done", done, 1'b1);
        chk("rand_count", idx, 8192);
        chk("rand_fd", fd_cnt, 1);
        rd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (fbib.read_en || busyb) rd_cnt++;
        end
        chk("rand_idle", rd_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
